// File: rtl/col2im_wb.sv
// Write-back stage: accumulates per-chunk partial sums, requantizes, and
// queues {addr, data} to output map memory. Optional macro: COL2IM_RELU_EN.
module col2im_wb #(
    parameter int PSUM_WIDTH     = 24,
    parameter int ACC_WIDTH      = 32,
    parameter int OUT_WIDTH      = 16,
    parameter int MAX_Y3         = 32,
    parameter int MAX_Out_DEEPTH = 16384,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en_col2im,
    input  logic [$clog2(MAX_Y3):0]               Y3,
    input  logic [15:0]                           n,
    input  logic [$clog2(MAX_Y3):0]               patch_i,
    input  logic [$clog2(MAX_Y3):0]               patch_j,
    input  logic [4:0]                            SHIFT,
    input  logic                                  psum_valid,
    output logic                                  psum_ready,
    input  logic signed [PSUM_WIDTH-1:0]          psum_data,
    input  logic                                  psum_last,
    output logic                                  wr_en,
    input  logic                                  wr_ready,
    output logic [$clog2(MAX_Out_DEEPTH):0]       wr_addr,
    output logic signed [OUT_WIDTH-1:0]           wr_data,
    output logic [15:0]                           out_cnt,
    output logic                                  busy
);

    localparam int YW = $clog2(MAX_Y3) + 1;
    localparam int AW = $clog2(MAX_Out_DEEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = ACC_WIDTH + 1;

    localparam logic [0:0] S_ACC  = 1'b0;
    localparam logic [0:0] S_PUSH = 1'b1;

    localparam logic signed [SW-1:0] OMAX =
        SW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] OMIN = -OMAX - SW'(1);

    logic [0:0]                  state;
    logic                        first;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] fin;
    logic [15:0]                 q_n;
    logic [YW-1:0]               q_y3;
    logic [YW-1:0]               q_i;
    logic [YW-1:0]               q_j;
    logic [4:0]                  q_shift;

    logic [AW-1:0]               f_addr [FIFO_DEPTH];
    logic signed [OUT_WIDTH-1:0] f_data [FIFO_DEPTH];
    logic [PW-1:0]               wp;
    logic [PW-1:0]               rp;
    logic [CW-1:0]               cnt;

    logic                        accept;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic                        empty;
    logic                        full;
    logic                        push;
    logic                        pop;
    logic [AW-1:0]               push_addr;
    logic signed [OUT_WIDTH-1:0] push_data;
    logic signed [SW-1:0]        fin_x;
    logic signed [SW-1:0]        rnd;
    logic signed [SW-1:0]        rq;
    logic signed [SW-1:0]        rsat;

    assign psum_ready = !rst && en_col2im && (state == S_ACC);
    assign accept     = psum_valid && psum_ready;
    assign acc_sum    = (first ? '0 : acc) + ACC_WIDTH'(psum_data);

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(FIFO_DEPTH));
    assign pop   = !empty && wr_ready;
    assign push  = (state == S_PUSH) && en_col2im && !full;

    // Address math is done at 32 bits and then truncated to the port width.
    assign push_addr = AW'(32'(q_n) * 32'(q_y3) * 32'(q_y3)
                         + 32'(q_i) * 32'(q_y3) + 32'(q_j));

    // One extra bit keeps the rounding add from overflowing.
    always_comb begin
        fin_x = SW'(fin);
        rnd   = fin_x + (SW'(1) << (q_shift - 5'd1));
        rq    = (q_shift == 5'd0) ? fin_x : (rnd >>> q_shift);
`ifdef COL2IM_RELU_EN
        if (rq < 0) rq = '0;
`endif
        if (rq > OMAX)      rsat = OMAX;
        else if (rq < OMIN) rsat = OMIN;
        else                rsat = rq;
        push_data = OUT_WIDTH'(rsat);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_ACC;
            first   <= 1'b1;
            acc     <= '0;
            fin     <= '0;
            q_n     <= '0;
            q_y3    <= '0;
            q_i     <= '0;
            q_j     <= '0;
            q_shift <= '0;
        end else if (!en_col2im) begin
            state <= S_ACC;
            first <= 1'b1;
            acc   <= '0;
        end else begin
            unique case (state)
                S_ACC: begin
                    if (accept) begin
                        acc   <= acc_sum;
                        first <= psum_last;
                        if (psum_last) begin
                            fin     <= acc_sum;
                            q_n     <= n;
                            q_y3    <= Y3;
                            q_i     <= patch_i;
                            q_j     <= patch_j;
                            q_shift <= SHIFT;
                            state   <= S_PUSH;
                        end
                    end
                end
                S_PUSH: begin
                    if (!full) state <= S_ACC;
                end
                default: state <= S_ACC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            f_addr[wp] <= push_addr;
            f_data[wp] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            out_cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) begin
                rp      <= rp + 1'b1;
                out_cnt <= out_cnt + 16'd1;
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign wr_en   = !empty;
    assign wr_addr = empty ? '0 : f_addr[rp];
    assign wr_data = empty ? '0 : f_data[rp];
    assign busy    = !first || (state == S_PUSH) || !empty;

endmodule

// File: tb/tb_col2im_wb.sv
// Directed + randomized bench for col2im_wb with an arithmetic reference
// model for address and requantized result.
module tb_col2im_wb;

    localparam int PSW = 24;
    localparam int YW  = 6;
    localparam int AW  = 15;
    localparam int OW  = 16;

    logic                  clk;
    logic                  rst;
    logic                  en_col2im;
    logic [YW-1:0]         Y3;
    logic [15:0]           n;
    logic [YW-1:0]         patch_i;
    logic [YW-1:0]         patch_j;
    logic [4:0]            SHIFT;
    logic                  psum_valid;
    logic                  psum_ready;
    logic signed [PSW-1:0] psum_data;
    logic                  psum_last;
    logic                  wr_en;
    logic                  wr_ready;
    logic [AW-1:0]         wr_addr;
    logic signed [OW-1:0]  wr_data;
    logic [15:0]           out_cnt;
    logic                  busy;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    col2im_wb #(
        .PSUM_WIDTH(24), .ACC_WIDTH(32), .OUT_WIDTH(16),
        .MAX_Y3(32), .MAX_Out_DEEPTH(16384), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .en_col2im(en_col2im), .Y3(Y3), .n(n),
        .patch_i(patch_i), .patch_j(patch_j), .SHIFT(SHIFT),
        .psum_valid(psum_valid), .psum_ready(psum_ready),
        .psum_data(psum_data), .psum_last(psum_last),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .out_cnt(out_cnt), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint model_data(input int sum, input int sh);
        longint f = longint'(sum);
        longint r;
        if (sh == 0) r = f;
        else         r = (f + (longint'(1) << (sh - 1))) >>> sh;
`ifdef COL2IM_RELU_EN
        if (r < 0) r = 0;
`endif
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    function automatic longint model_addr(input int nn, input int y,
                                          input int ii, input int jj);
        return (longint'(nn) * y * y + longint'(ii) * y + jj) & 64'h7fff;
    endfunction

    task automatic send(input int d, input bit last);
        int k = 0;
        psum_valid = 1'b1;
        psum_data  = PSW'(d);
        psum_last  = last;
        while (!psum_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!psum_ready) chk("psum_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        psum_valid = 1'b0;
        psum_last  = 1'b0;
    endtask

    task automatic expect_write(input string tag, input longint ea,
                                input longint ed);
        int k = 0;
        while (!wr_en && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_wr_en"}, wr_en, 1);
        chk({tag, "_addr"}, wr_addr, ea);
        chk({tag, "_data"}, wr_data, ed);
        if (wr_ready && wr_en) exp_cnt++;
        @(negedge clk);
    endtask

    initial begin
        int y, nn, ii, jj, sh, nb, sum, d;
        rst = 1'b1; en_col2im = 1'b0; Y3 = '0; n = '0;
        patch_i = '0; patch_j = '0; SHIFT = '0;
        psum_valid = 1'b0; psum_data = '0; psum_last = 1'b0;
        wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_psum_ready", psum_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_out_cnt", out_cnt, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        en_col2im = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", psum_ready, 1);

        // three-chunk accumulation with exact latency
        Y3 = 6'd4; n = 16'd1; patch_i = 6'd2; patch_j = 6'd3; SHIFT = 5'd0;
        send(10, 0);
        send(20, 0);
        chk("busy_acc", busy, 1);
        send(30, 1);
        chk("bubble_ready", psum_ready, 0);
        chk("wr_en_t1", wr_en, 0);
        @(negedge clk);
        chk("wr_en_t2", wr_en, 1);
        expect_write("t1", 27, 60);
        chk("t1_out_cnt", out_cnt, exp_cnt);
        chk("t1_busy_idle", busy, 0);

        // rounding and sign
        SHIFT = 5'd2;
        send(7, 1);
        expect_write("rnd_pos", 27, 2);
        send(-6, 1);
        expect_write("rnd_neg", 27, model_data(-6, 2));
`ifdef COL2IM_RELU_EN
        chk("rnd_neg_const", wr_data, 0);
`endif

        // saturation
        SHIFT = 5'd0;
        send(100000, 1);
        expect_write("sat_hi", 27, 32767);
        send(-100000, 1);
        expect_write("sat_lo", 27, model_data(-100000, 0));

        // randomized patches against the model
        for (int t = 0; t < 12; t++) begin
            y  = int'($urandom_range(1, 32));
            nn = int'($urandom_range(0, 65535));
            ii = int'($urandom_range(0, y - 1));
            jj = int'($urandom_range(0, y - 1));
            sh = int'($urandom_range(0, 14));
            nb = int'($urandom_range(1, 4));
            Y3 = YW'(y); n = 16'(nn);
            patch_i = YW'(ii); patch_j = YW'(jj); SHIFT = 5'(sh);
            sum = 0;
            for (int b = 0; b < nb; b++) begin
                d = int'($urandom_range(0, (1 << 24) - 1)) - (1 << 23);
                sum += d;
                send(d, b == nb - 1);
            end
            expect_write($sformatf("rand%0d", t),
                         model_addr(nn, y, ii, jj), model_data(sum, sh));
        end
        chk("rand_out_cnt", out_cnt, exp_cnt);

        // backpressure: four fill the FIFO, fifth waits in PUSH
        wr_ready = 1'b0;
        Y3 = 6'd8; n = 16'd0; patch_i = 6'd0; SHIFT = 5'd0;
        for (int k = 0; k < 5; k++) begin
            patch_j = YW'(k);
            send(100 + k, 1);
        end
        repeat (3) @(negedge clk);
        chk("stall_ready", psum_ready, 0);
        chk("stall_busy", busy, 1);
        chk("stall_head_addr", wr_addr, 0);
        chk("stall_head_data", wr_data, 100);
        chk("stall_out_cnt", out_cnt, exp_cnt);
        wr_ready = 1'b1;
        for (int k = 0; k < 5; k++)
            expect_write($sformatf("drain%0d", k), k, 100 + k);
        chk("drain_out_cnt", out_cnt, exp_cnt);

        // enable drop discards a partial sum
        Y3 = 6'd4; n = 16'd2; patch_i = 6'd1; patch_j = 6'd1;
        send(10, 0);
        send(20, 0);
        en_col2im = 1'b0;
        @(negedge clk);
        en_col2im = 1'b1;
        chk("en_drop_busy", busy, 0);
        send(5, 1);
        expect_write("en_drop", 37, 5);

        // reset mid-operation
        wr_ready = 1'b0;
        send(1, 1);
        send(2, 1);
        send(3, 0);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_wr_en", wr_en, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_cnt", out_cnt, 0);
        rst = 1'b0;
        wr_ready = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        chk("post_rst_wr_en", wr_en, 0);
        send(9, 1);
        expect_write("post_rst", 37, 9);
        chk("post_rst_out_cnt", out_cnt, exp_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
